// File: rtl/alarm_trigger.sv
// alarm_trigger: alarm-clock ring/snooze sequencer.
// Compares the current time against the alarm setting, rings on the first
// cycle of a matching minute, and handles snooze, dismiss and ring timeout.
// Optional build macro: ALARM_TRIGGER_SNOOZE_LIMIT_EN (caps snoozes at MAX_SNOOZES).
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | armed or disarmed, waiting for the rising edge of a time match
// ST_RINGING | buzzer requested, ring timer counting down to auto-off
// ST_SNOOZE  | buzzer silenced, snooze timer counting down to re-ring
module alarm_trigger #(
  parameter int SNOOZE_SECONDS       = 540,
  parameter int RING_TIMEOUT_SECONDS = 300,
  parameter int MAX_SNOOZES          = 3
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Tick_1Hz,
  input  logic [4:0] i_Hour,
  input  logic [5:0] i_Minute,
  input  logic [4:0] i_Alarm_Hour,
  input  logic [5:0] i_Alarm_Minute,
  input  logic       i_Alarm_Enable,
  input  logic       i_Snooze,
  input  logic       i_Dismiss,
  output logic       o_Alarm_On,
  output logic       o_Snoozing,
  output logic       o_Timeout,
  output logic [1:0] o_Snooze_Count
);

  localparam int MAX_SECONDS = (SNOOZE_SECONDS > RING_TIMEOUT_SECONDS) ?
                               SNOOZE_SECONDS : RING_TIMEOUT_SECONDS;
  localparam int CW = $clog2(MAX_SECONDS + 1);
  localparam logic [CW-1:0] SNOOZE_LOAD = CW'(SNOOZE_SECONDS);
  localparam logic [CW-1:0] RING_LOAD   = CW'(RING_TIMEOUT_SECONDS);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

`ifdef ALARM_TRIGGER_SNOOZE_LIMIT_EN
  localparam logic LIMIT_EN = 1'b1;
`else
  localparam logic LIMIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_t;

  state_t          r_State;
  logic [CW-1:0]   r_Count;
  logic [1:0]      r_Snooze_Count;
  logic            r_Timeout;
  logic            r_Match_Prev;

  state_t          w_Next_State;
  logic [CW-1:0]   w_Next_Count;
  logic [1:0]      w_Next_Snooze_Count;
  logic            w_Next_Timeout;
  logic            w_Match;
  logic            w_Trigger;
  logic            w_Limit_Hit;
  logic            w_Snooze_Ok;

  assign w_Match   = (i_Hour == i_Alarm_Hour) && (i_Minute == i_Alarm_Minute);
  // Edge of the match, so a held matching minute (or enabling inside one) never rings.
  assign w_Trigger = w_Match && !r_Match_Prev && i_Alarm_Enable;

  // The limit compare is always built; the macro only decides whether it gates snooze.
  assign w_Limit_Hit = ({30'd0, r_Snooze_Count} >= 32'(MAX_SNOOZES));
  assign w_Snooze_Ok = i_Snooze && !(LIMIT_EN && w_Limit_Hit);

  // State, shared down-counter, snooze tally, timeout pulse and match history.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State        <= ST_IDLE;
      r_Count        <= '0;
      r_Snooze_Count <= 2'd0;
      r_Timeout      <= 1'b0;
      r_Match_Prev   <= 1'b1;
    end else begin
      r_State        <= w_Next_State;
      r_Count        <= w_Next_Count;
      r_Snooze_Count <= w_Next_Snooze_Count;
      r_Timeout      <= w_Next_Timeout;
      r_Match_Prev   <= w_Match;
    end
  end

  // Next-state logic; priority is enable-low, dismiss, snooze, tick.
  always_comb begin
    w_Next_State        = r_State;
    w_Next_Count        = r_Count;
    w_Next_Snooze_Count = r_Snooze_Count;
    w_Next_Timeout      = 1'b0;
    case (r_State)
      ST_IDLE: begin
        if (w_Trigger) begin
          w_Next_State = ST_RINGING;
          w_Next_Count = RING_LOAD;
        end
      end
      ST_RINGING: begin
        if (!i_Alarm_Enable || i_Dismiss) begin
          w_Next_State = ST_IDLE;
        end else if (w_Snooze_Ok) begin
          w_Next_State = ST_SNOOZE;
          w_Next_Count = SNOOZE_LOAD;
          if (r_Snooze_Count != 2'd3) begin
            w_Next_Snooze_Count = r_Snooze_Count + 2'd1;
          end
        end else if (i_Tick_1Hz) begin
          if (r_Count == CNT_ONE) begin
            w_Next_State   = ST_IDLE;
            w_Next_Timeout = 1'b1;
          end else if (r_Count != '0) begin
            w_Next_Count = r_Count - CNT_ONE;
          end
        end
      end
      ST_SNOOZE: begin
        if (!i_Alarm_Enable || i_Dismiss) begin
          w_Next_State = ST_IDLE;
        end else if (i_Tick_1Hz) begin
          if (r_Count == CNT_ONE) begin
            w_Next_State = ST_RINGING;
            w_Next_Count = RING_LOAD;
          end else if (r_Count != '0) begin
            w_Next_Count = r_Count - CNT_ONE;
          end
        end
      end
      default: begin
        w_Next_State = ST_IDLE;
      end
    endcase
    // Every entry to (or stay in) IDLE ends the alarm event.
    if (w_Next_State == ST_IDLE) begin
      w_Next_Count        = '0;
      w_Next_Snooze_Count = 2'd0;
    end
  end

  assign o_Alarm_On     = (r_State == ST_RINGING);
  assign o_Snoozing     = (r_State == ST_SNOOZE);
  assign o_Timeout      = r_Timeout;
  assign o_Snooze_Count = r_Snooze_Count;

endmodule

// File: tb/tb_alarm_trigger.sv
// Scoreboard bench for alarm_trigger: stimulus pushes expected output
// snapshots tagged with the cycle they apply to; a monitor pops and compares.
module tb_alarm_trigger;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [4:0] al_hour;
  logic [5:0] al_minute;
  logic       enable;
  logic       snooze;
  logic       dismiss;
  logic       alarm_on;
  logic       snoozing;
  logic       timeout;
  logic [1:0] snz_cnt;

  alarm_trigger dut (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_Tick_1Hz     (tick),
    .i_Hour         (hour),
    .i_Minute       (minute),
    .i_Alarm_Hour   (al_hour),
    .i_Alarm_Minute (al_minute),
    .i_Alarm_Enable (enable),
    .i_Snooze       (snooze),
    .i_Dismiss      (dismiss),
    .o_Alarm_On     (alarm_on),
    .o_Snoozing     (snoozing),
    .o_Timeout      (timeout),
    .o_Snooze_Count (snz_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         due;
    logic       on;
    logic       snz;
    logic       to;
    logic [1:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    cyc   = 0;
  int    total = 0;
  int    bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation whose cycle has arrived.
  exp_t  m_e;
  string m_n;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      m_e = exp_q.pop_front();
      m_n = name_q.pop_front();
      total++;
      if ({alarm_on, snoozing, timeout, snz_cnt} !== {m_e.on, m_e.snz, m_e.to, m_e.cnt}) begin
        bad++;
        $display("FAIL %s: got on=%b snz=%b to=%b cnt=%0d, want on=%b snz=%b to=%b cnt=%0d",
                 m_n, alarm_on, snoozing, timeout, snz_cnt, m_e.on, m_e.snz, m_e.to, m_e.cnt);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string n, input logic on, input logic snz,
                            input logic to, input logic [1:0] cnt);
    exp_t e;
    e.due = cyc;
    e.on  = on;
    e.snz = snz;
    e.to  = to;
    e.cnt = cnt;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
  endtask

  task automatic retrigger();
    minute = 6'd31;
    step();
    minute = 6'd30;
    step();
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1;
    step();
    snooze = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; snooze = 1'b0; dismiss = 1'b0; enable = 1'b1;
    hour = 5'd7; minute = 6'd29; al_hour = 5'd7; al_minute = 6'd30;
    step();
    step();
    expect_out("reset", 0, 0, 0, 2'd0);
    rst = 1'b0;
    step();
    expect_out("idle_0729", 0, 0, 0, 2'd0);

    // 07:29 -> 07:30 rings one cycle later; held 07:30 after dismiss stays quiet
    minute = 6'd30;
    step();
    expect_out("ring_start", 1, 0, 0, 2'd0);
    dismiss = 1'b1;
    step();
    dismiss = 1'b0;
    expect_out("dismiss", 0, 0, 0, 2'd0);
    repeat (5) step();
    expect_out("no_rering_held", 0, 0, 0, 2'd0);

    // snooze, snooze ignored while snoozing, re-ring after exactly 540 ticks
    retrigger();
    expect_out("ring2", 1, 0, 0, 2'd0);
    pulse_snooze();
    expect_out("snooze1", 0, 1, 0, 2'd1);
    pulse_snooze();
    expect_out("snooze_in_snooze", 0, 1, 0, 2'd1);
    do_ticks(539);
    expect_out("snooze_539", 0, 1, 0, 2'd1);
    do_ticks(1);
    expect_out("snooze_540", 1, 0, 0, 2'd1);

    // unattended ring times out after 300 ticks with a single pulse
    do_ticks(299);
    expect_out("ring_299", 1, 0, 0, 2'd1);
    tick = 1'b1;
    step();
    tick = 1'b0;
    expect_out("timeout_pulse", 0, 0, 1, 2'd0);
    step();
    expect_out("timeout_single", 0, 0, 0, 2'd0);

    // snooze and dismiss together while ringing: dismiss wins, count clears
    retrigger();
    pulse_snooze();
    do_ticks(540);
    expect_out("ring_after_snz", 1, 0, 0, 2'd1);
    snooze = 1'b1;
    dismiss = 1'b1;
    step();
    snooze = 1'b0;
    dismiss = 1'b0;
    expect_out("snz_dis_same", 0, 0, 0, 2'd0);

    // enable low aborts ringing; re-enabling inside the matching minute does not ring
    retrigger();
    expect_out("ring_en", 1, 0, 0, 2'd0);
    enable = 1'b0;
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    expect_out("en_low_abort", 0, 0, 0, 2'd0);
    enable = 1'b1;
    repeat (3) step();
    expect_out("enable_in_match", 0, 0, 0, 2'd0);

    // reset during SNOOZE at 07:30: all clear and no ring after release
    retrigger();
    pulse_snooze();
    expect_out("snooze_pre_rst", 0, 1, 0, 2'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_out("rst_in_snooze", 0, 0, 0, 2'd0);
    repeat (4) step();
    expect_out("no_ring_after_rst", 0, 0, 0, 2'd0);

    // fourth snooze: ignored with the limit build, accepted (count saturated) otherwise
    retrigger();
    for (int k = 1; k <= 3; k++) begin
      pulse_snooze();
      expect_out("snooze_n", 0, 1, 0, 2'(k));
      do_ticks(540);
      expect_out("rering_n", 1, 0, 0, 2'(k));
    end
    pulse_snooze();
`ifdef ALARM_TRIGGER_SNOOZE_LIMIT_EN
    expect_out("fourth_snooze", 1, 0, 0, 2'd3);
`else
    expect_out("fourth_snooze", 0, 1, 0, 2'd3);
`endif
    dismiss = 1'b1;
    step();
    dismiss = 1'b0;
    expect_out("final_dismiss", 0, 0, 0, 2'd0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
